// File: rtl/led_scan_decoder.sv
// led_scan_decoder: recovers per-digit BCD/dp from a muxed 7-seg scan bus.
// Optional FrameCount output is enabled by LED_SCAN_FRAME_CNT_EN.
module led_scan_decoder #(
  parameter int DIGITS = 8,
  parameter int SETTLE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            LEDData,
  input  logic [DIGITS-1:0]     DigSel,
  output logic [4*DIGITS-1:0]   Digits,
  output logic [DIGITS-1:0]     DpMask,
  output logic [DIGITS-1:0]     ErrMask,
  output logic                  FrameValid,
  output logic                  SelErr
`ifdef LED_SCAN_FRAME_CNT_EN
  ,
  output logic [15:0]           FrameCount
`endif
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam int SW = 8 + DIGITS;
  localparam logic [CW-1:0] SMAX = CW'(SETTLE);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } state_t;

  state_t state;
  logic [SW-1:0] s;
  logic [SW-1:0] s_new;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [DIGITS-1:0] seen;
  logic [DIGITS-1:0] seen_upd;
  logic [DIGITS-1:0] sel_low;
  logic changed;
  logic capture;
  logic one_hot;
  logic multi;
  logic hit;
  logic full;
  logic [4:0] dec;

  // Returns {error, value}.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    unique case (seg)
      7'b1000000: decode = {1'b0, 4'h0};
      7'b1111001: decode = {1'b0, 4'h1};
      7'b0100100: decode = {1'b0, 4'h2};
      7'b0110000: decode = {1'b0, 4'h3};
      7'b0011001: decode = {1'b0, 4'h4};
      7'b0010010: decode = {1'b0, 4'h5};
      7'b0000010: decode = {1'b0, 4'h6};
      7'b1111000: decode = {1'b0, 4'h7};
      7'b0000000: decode = {1'b0, 4'h8};
      7'b0010000: decode = {1'b0, 4'h9};
      7'b1111111: decode = {1'b0, 4'hB};
      7'b0000110: decode = {1'b1, 4'hE};
      default:    decode = {1'b1, 4'hF};
    endcase
  endfunction

  assign s_new = {LEDData, DigSel};
  assign changed = (s_new != s);
  assign sel_low = ~DigSel;
  assign one_hot = $onehot(sel_low);
  assign multi = (sel_low != '0) && !one_hot;
  assign dec = decode(LEDData[6:0]);

  always_comb begin
    cnt_next = cnt;
    if (changed) cnt_next = ONE;
    else if (cnt != SMAX) cnt_next = cnt + ONE;
  end

  // One capture per dwell: only while settling or on the changing edge.
  assign capture = (cnt_next == SMAX) &&
                   (changed || state == ST_SETTLE);
  assign hit = capture && one_hot;
  assign seen_upd = seen | (hit ? sel_low : '0);
  assign full = hit && (&seen_upd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s          <= '1;
      cnt        <= '0;
      state      <= ST_IDLE;
      seen       <= '0;
      Digits     <= {DIGITS{4'hB}};
      DpMask     <= '0;
      ErrMask    <= '0;
      FrameValid <= 1'b0;
      SelErr     <= 1'b0;
`ifdef LED_SCAN_FRAME_CNT_EN
      FrameCount <= '0;
`endif
    end else begin
      s          <= s_new;
      cnt        <= cnt_next;
      FrameValid <= full;
      seen       <= full ? '0 : seen_upd;
      if (capture)
        state <= (sel_low == '0) ? ST_IDLE : ST_HOLD;
      else if (changed)
        state <= ST_SETTLE;
      if (capture && multi)
        SelErr <= 1'b1;
      if (hit) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (sel_low[i]) begin
            Digits[4*i +: 4] <= dec[3:0];
            DpMask[i]        <= ~LEDData[7];
            ErrMask[i]       <= dec[4];
          end
        end
      end
`ifdef LED_SCAN_FRAME_CNT_EN
      if (full && FrameCount != 16'hFFFF)
        FrameCount <= FrameCount + 16'd1;
`endif
    end
  end

endmodule

// File: tb/tb_led_scan_decoder.sv
// tb_led_scan_decoder: directed + random scan traffic vs. a dwell-length model.
// Covers the LED_SCAN_FRAME_CNT_EN build when that macro is defined.
module tb_led_scan_decoder;

  localparam int DIGITS = 8;
  localparam int SETTLE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] led = 8'hFF;
  logic [7:0] sel = 8'hFF;
  logic [31:0] Digits;
  logic [7:0] DpMask;
  logic [7:0] ErrMask;
  logic FrameValid;
  logic SelErr;
`ifdef LED_SCAN_FRAME_CNT_EN
  logic [15:0] FrameCount;
`endif

  led_scan_decoder #(.DIGITS(DIGITS), .SETTLE(SETTLE)) dut (
    .clk(clk),
    .rst(rst),
    .LEDData(led),
    .DigSel(sel),
    .Digits(Digits),
    .DpMask(DpMask),
    .ErrMask(ErrMask),
    .FrameValid(FrameValid),
    .SelErr(SelErr)
`ifdef LED_SCAN_FRAME_CNT_EN
    ,
    .FrameCount(FrameCount)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;

  logic [6:0] glyph [10];
  logic [3:0] m_dig [DIGITS];
  logic [7:0] m_dp, m_err, m_seen;
  logic m_fv, m_selerr;
  logic [15:0] prev;
  int dwell;
  int m_fc;

  // Returns {error, value} from a glyph lookup.
  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    for (int k = 0; k < 10; k++)
      if (glyph[k] == p) return {1'b0, 4'(k)};
    if (p == 7'h7F) return {1'b0, 4'hB};
    if (p == 7'b0000110) return {1'b1, 4'hE};
    return {1'b1, 4'hF};
  endfunction

  function automatic logic [31:0] m_pack();
    logic [31:0] r;
    for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = m_dig[k];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < DIGITS; k++) m_dig[k] = 4'hB;
    m_dp = 0; m_err = 0; m_seen = 0;
    m_fv = 0; m_selerr = 0;
    prev = 16'hFFFF; dwell = 0; m_fc = 0;
  endtask

  // A dwell is a run of identical samples; capture when it is SETTLE long.
  task automatic model_edge();
    logic [15:0] v;
    logic [4:0] d;
    v = {led, sel};
    if (v != prev) dwell = 1;
    else dwell++;
    prev = v;
    m_fv = 0;
    if (dwell == SETTLE) begin
      if ($countones(~sel) >= 2) m_selerr = 1;
      else if ($countones(~sel) == 1) begin
        for (int k = 0; k < DIGITS; k++) begin
          if (!sel[k]) begin
            d = ref_decode(led[6:0]);
            m_dig[k] = d[3:0];
            m_dp[k] = ~led[7];
            m_err[k] = d[4];
            m_seen[k] = 1;
          end
        end
        if (m_seen == 8'hFF) begin
          m_fv = 1;
          m_seen = 0;
          if (m_fc < 65535) m_fc++;
        end
      end
    end
  endtask

  task automatic compare(input string tag);
    logic [50:0] got, exp;
    got = {Digits, DpMask, ErrMask, FrameValid, SelErr};
    exp = {m_pack(), m_dp, m_err, m_fv, m_selerr};
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s t=%0t got %h exp %h", tag, $time, got, exp);
    end
`ifdef LED_SCAN_FRAME_CNT_EN
    vectors++;
    assert (FrameCount === 16'(m_fc)) else begin
      miscompares++;
      $error("FAIL %s_fcnt got %0d exp %0d", tag, FrameCount, m_fc);
    end
`endif
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (FrameValid) pulses++;
    compare("step");
  endtask

  task automatic hold(input logic [7:0] l, input logic [7:0] s, input int n);
    led = l;
    sel = s;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1;
    model_reset();
    #2;
    compare("reset");
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic scan(input int first, input int last);
    for (int k = first; k <= last; k++)
      hold({1'b1, glyph[k]}, ~(8'd1 << k), 6);
  endtask

  initial begin
    int n, p;
    logic [7:0] l, s;
    glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000};
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare("reset_hold");
    rst = 0;
    hold(8'hFF, 8'hFF, 100);
    chk("idle_digits", Digits, 32'hBBBBBBBB);
    chk("idle_pulses", pulses, 0);

    hold(8'b10100100, 8'hFE, 4);
    chk("d0_val", {28'd0, Digits[3:0]}, 32'd2);
    chk("d0_dp", {31'd0, DpMask[0]}, 0);
    hold(8'b11111001, 8'hFD, 3);
    hold(8'hFF, 8'hFF, 2);
    chk("short_dwell", {28'd0, Digits[7:4]}, 32'hB);

    do_reset();
    pulses = 0;
    for (int k = 0; k < 8; k++)
      hold({(k == 2) ? 1'b0 : 1'b1, glyph[k]}, ~(8'd1 << k), 6);
    chk("frame_pulses", pulses, 1);
    chk("frame_digits", Digits, 32'h76543210);
    chk("frame_dp", {24'd0, DpMask}, 32'h04);

    hold(8'b10000110, 8'hF7, 5);
    chk("e_glyph", {27'd0, ErrMask[3], Digits[15:12]}, 32'h1E);
    hold(8'b10101010, 8'hF7, 5);
    chk("f_glyph", {27'd0, ErrMask[3], Digits[15:12]}, 32'h1F);
    hold(8'b10010000, 8'hF7, 5);
    chk("nine", {27'd0, ErrMask[3], Digits[15:12]}, 32'h09);

    hold(8'hC0, 8'hFC, 4);
    chk("selerr", {31'd0, SelErr}, 1);
    chk("selerr_digits", Digits, 32'h76549210);
    scan(0, 7);
    chk("selerr_sticky", {31'd0, SelErr}, 1);

    do_reset();
    scan(0, 4);
    do_reset();
    pulses = 0;
    scan(0, 6);
    chk("rst_partial", pulses, 0);
    scan(7, 7);
    chk("rst_frame", pulses, 1);
`ifdef LED_SCAN_FRAME_CNT_EN
    chk("rst_fcnt", {16'd0, FrameCount}, 1);
`endif

    for (int r = 0; r < 400; r++) begin
      p = $urandom_range(0, 9);
      if (p <= 6) l[6:0] = glyph[$urandom_range(0, 9)];
      else if (p == 7) l[6:0] = 7'h7F;
      else if (p == 8) l[6:0] = 7'b0000110;
      else l[6:0] = 7'($urandom);
      l[7] = 1'($urandom);
      p = $urandom_range(0, 19);
      if (p < 16) s = ~(8'd1 << $urandom_range(0, 7));
      else if (p < 18) s = 8'hFF;
      else s = 8'($urandom);
      n = $urandom_range(1, 7);
      hold(l, s, n);
      if (r % 97 == 96) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_scan_decoder.md
Name: led_scan_decoder

Overview:
- Receive-side counterpart of the digit-to-segment encoder: monitors a multiplexed common-anode 7-segment display bus (active-low segments, active-low digit selects) and recovers the per-digit BCD values and decimal points.
- Sits beside the display driver in the digital clock for self-check and for readback by the test bench / debug logic.
- Filters scan ghosting with a settle counter, flags unrecognised patterns and pulses once per completed frame.

Parameters:
DIGITS, 8, number of multiplexed digits (1..16).
SETTLE, 4, consecutive cycles the registered {LEDData, DigSel} must be unchanged before capture (>=1).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
LEDData  in  8  segment bus, active-low; bit7 = dp, bits6..0 = g,f,e,d,c,b,a.
DigSel  in  DIGITS  digit enables, active-low, one-hot-low when a digit is driven.
Digits  out  4*DIGITS  decoded value of digit i on [4i+3:4i].
DpMask  out  DIGITS  bit i = dp of digit i lit.
ErrMask  out  DIGITS  bit i = last captured pattern of digit i was not a valid decimal digit or blank.
FrameValid  out  1  one-cycle pulse when every digit has been captured since the previous pulse/reset.
SelErr  out  1  sticky: more than one digit selected while stable.

Behaviour:
- Clocking: one clock; reset is asynchronous and active-high. Inputs are in the clk domain; registered once into sample register S.
- Reset values: Digits all 4'hB, DpMask 0, ErrMask 0, FrameValid 0, SelErr 0, S = all ones, stable counter 0, seen mask 0, state IDLE.
- Stability: counter CNT resets to 1 when the new S differs from the old S, else increments (saturating at SETTLE). Capture at the edge where CNT reaches SETTLE. Inputs changed before sampling edge t0 and held: capture at edge t0+SETTLE-1. Outputs are visible after that edge.
- Exactly one capture per dwell. No further capture until S changes.
- FSM:
  - IDLE: DigSel all high or not yet stable.
  - SETTLE: counting.
  - HOLD: captured, waiting for a change.
  - Any change of S -> SETTLE from any state.
- Select classes at capture:
  - All high (blanking): no capture, no error.
  - Exactly one low bit i: write digit i.
  - Two or more low: no write, SelErr <= 1 (cleared only by rst).
- Decode of LEDData[6:0]:
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9: error clear.
  - 1111111 -> 4'hB (blank): error clear.
  - 0000110 -> 4'hE ("E" glyph): error set.
  - Any other pattern -> 4'hF: error set.
  - DpMask[i] <= ~LEDData[7], independent of the decoded value.
- Frame:
  - Capture of digit i sets seen[i].
  - When seen becomes all ones (including the current capture), FrameValid = 1 for exactly that cycle and seen clears at the same edge.
  - Recapturing an already-seen digit overwrites its value and does not advance the frame.
- Scan order is free.
- Reset mid-dwell or mid-frame discards the count and partial seen mask. Outputs return to their reset values.
- Pure combinational decode plus the registers above. No multicycle paths.

Optional Feature:
LED_SCAN_FRAME_CNT_EN
- Defined: adds output port FrameCount (16 bits). It increments on each FrameValid pulse, saturates at 16'hFFFF, and resets to 0 on rst.
- Not defined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset held, then released with DigSel=8'hFF -> Digits=32'hBBBBBBBB, all flags 0, no FrameValid for 100 cycles.
- DigSel=8'hFE, LEDData=8'b10100100 held 4 cycles -> Digits[3:0]=2, DpMask[0]=0, ErrMask[0]=0 after edge t0+3. Held 3 cycles then changed -> no capture.
- Scan digits 0..7 with 0,1,2,3,4,5,6,7 (dwell 6 cycles each, dp on digit 2 via 8'b00100100 equivalent) -> single FrameValid pulse on digit-7 capture, Digits=32'h76543210, DpMask=8'h04.
- Digit 3 driven with 8'b10000110 -> Digits[15:12]=E, ErrMask[3]=1. Then with 8'b10101010 -> F, ErrMask[3]=1. Then 8'b10010000 -> 9, ErrMask[3]=0.
- DigSel=8'hFC stable 4 cycles -> SelErr=1, Digits unchanged. SelErr persists through later valid scans until rst.
- Assert rst after 5 of 8 digits captured, release, scan 8 digits -> exactly one FrameValid, and only after all 8 new captures. With LED_SCAN_FRAME_CNT_EN, FrameCount=1.
